vppm_tx_sequencer: RTL

Frame sequencer for the VPPM transmitter. It takes bytes over a valid/ready handshake and emits a preamble followed by serialized data symbols. For each symbol it reprograms the duty (pulse width) and delay (pulse position) inputs of the downstream PWM block. It also owns the symbol timer, so the PWM block only ever sees stable parameters that change on symbol boundaries.

---
 rtl/vppm_tx_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/vppm_tx_sequencer.sv
// Frame sequencer for the VPPM transmitter: accepts bytes, emits a 1010.. preamble then
// data symbols, and drives stable duty/delay parameters to the PWM block on symbol boundaries.
module vppm_tx_sequencer #(
  parameter int W             = 26,
  parameter int SYM_PERIOD    = 10000,
  parameter int PREAMBLE_SYMS = 8,
  parameter bit MSB_FIRST     = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] dim_duty,
  input  logic [7:0]   tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic         pwm_en,
  output logic [W-1:0] pwm_duty,
  output logic [W-1:0] pwm_delay,
  output logic         sym_stb,
  output logic         busy,
  output logic         frame_done
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

  localparam logic [W-1:0] PERIOD   = W'(SYM_PERIOD);
  localparam logic [W-1:0] CNT_LAST = W'(SYM_PERIOD - 1);
  localparam logic [7:0]   PRE_LAST = 8'(PREAMBLE_SYMS - 1);

  state_t       state;
  logic [W-1:0] sym_cnt;
  logic [W-1:0] duty_lat;
  logic [W-1:0] clamped;
  logic [7:0]   shreg;
  logic [7:0]   pre_idx;
  logic [2:0]   bit_idx;
  logic         armed;
  logic         sym_end;
  logic         byte_end;
  logic         accept;

  // armed keeps tx_ready low while reset is held and for the edge that releases it
  assign sym_end  = (sym_cnt == CNT_LAST);
  assign byte_end = (state == DATA) && sym_end && (bit_idx == 3'd7);
  assign tx_ready = armed && ((state == IDLE) || byte_end);
  assign accept   = tx_valid && tx_ready;

  always_comb begin
    clamped = dim_duty;
    if (dim_duty == '0)
      clamped = W'(1);
    else if (dim_duty > CNT_LAST)
      clamped = CNT_LAST;
  end

  function automatic logic [W-1:0] delay_for(input logic b, input logic [W-1:0] d);
    return b ? (PERIOD - d) : '0;
  endfunction

  function automatic logic first_bit(input logic [7:0] x);
    return MSB_FIRST ? x[7] : x[0];
  endfunction

  function automatic logic second_bit(input logic [7:0] x);
    return MSB_FIRST ? x[6] : x[1];
  endfunction

  function automatic logic [7:0] shifted(input logic [7:0] x);
    return MSB_FIRST ? {x[6:0], 1'b0} : {1'b0, x[7:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sym_cnt    <= '0;
      duty_lat   <= '0;
      shreg      <= '0;
      pre_idx    <= '0;
      bit_idx    <= '0;
      armed      <= 1'b0;
      pwm_en     <= 1'b0;
      pwm_duty   <= '0;
      pwm_delay  <= '0;
      sym_stb    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      armed      <= 1'b1;
      sym_stb    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= PREAMBLE;
            shreg     <= tx_data;
            duty_lat  <= clamped;
            sym_cnt   <= '0;
            pre_idx   <= '0;
            bit_idx   <= '0;
            sym_stb   <= 1'b1;
            pwm_en    <= 1'b1;
            busy      <= 1'b1;
            pwm_duty  <= clamped;
            pwm_delay <= delay_for(1'b1, clamped);
          end
        end
        PREAMBLE: begin
          if (sym_end) begin
            sym_cnt <= '0;
            sym_stb <= 1'b1;
            if (pre_idx == PRE_LAST) begin
              state     <= DATA;
              bit_idx   <= '0;
              pwm_delay <= delay_for(first_bit(shreg), duty_lat);
            end else begin
              // next preamble index is even (a 1 symbol) exactly when the current one is odd
              pre_idx   <= pre_idx + 8'd1;
              pwm_delay <= delay_for(pre_idx[0], duty_lat);
            end
          end else begin
            sym_cnt <= sym_cnt + W'(1);
          end
        end
        DATA: begin
          if (!sym_end) begin
            sym_cnt <= sym_cnt + W'(1);
          end else if (bit_idx != 3'd7) begin
            sym_cnt   <= '0;
            sym_stb   <= 1'b1;
            bit_idx   <= bit_idx + 3'd1;
            shreg     <= shifted(shreg);
            pwm_delay <= delay_for(second_bit(shreg), duty_lat);
          end else if (accept) begin
            sym_cnt   <= '0;
            sym_stb   <= 1'b1;
            bit_idx   <= '0;
            shreg     <= tx_data;
            pwm_delay <= delay_for(first_bit(tx_data), duty_lat);
          end else begin
            state      <= IDLE;
            sym_cnt    <= '0;
            bit_idx    <= '0;
            pwm_en     <= 1'b0;
            pwm_duty   <= '0;
            pwm_delay  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
